// File: rtl/multi_channel_clock_generator.sv
// N_CH-channel programmable divided-clock / tick generator with double-buffered period and high-time.
// Optional phase-alignment input SYNC is built only when CLKGEN_SYNC_START_EN is defined.
module multi_channel_clock_generator #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic [N_CH-1:0]       ENABLE,
  input  logic [N_CH-1:0]       LOAD,
  input  logic [N_CH*WIDTH-1:0] PERIOD,
  input  logic [N_CH*WIDTH-1:0] HIGH_TIME,
`ifdef CLKGEN_SYNC_START_EN
  input  logic                  SYNC,
`endif
  output logic [N_CH-1:0]       CLK_OUT,
  output logic [N_CH-1:0]       TICK,
  output logic [N_CH-1:0]       PENDING
);

  // state | meaning
  // IDLE  | counter held at 0, outputs low; waits for ENABLE with active period >= 2
  // RUN   | counter cycles 0..P-1; CLK_OUT = counter < H, TICK = counter == 0
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(2);

  logic sync_s;

`ifdef CLKGEN_SYNC_START_EN
  assign sync_s = SYNC;
`else
  assign sync_s = 1'b0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_q, per_d, hi_q, hi_d;
    logic [WIDTH-1:0] sh_per_q, sh_per_d, sh_hi_q, sh_hi_d;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
    logic [WIDTH-1:0] per_in, hi_in, per_new, hi_new;
    logic             wrap, apply;

    assign per_in = PERIOD[i*WIDTH +: WIDTH];
    assign hi_in  = HIGH_TIME[i*WIDTH +: WIDTH];

    always_comb begin
      // Newest setting: a same-edge LOAD beats the shadow, which beats the active value.
      per_new = per_q;
      hi_new  = hi_q;
      if (LOAD[i]) begin
        per_new = per_in;
        hi_new  = hi_in;
      end else if (pend_q) begin
        per_new = sh_per_q;
        hi_new  = sh_hi_q;
      end

      wrap  = (state_q == ST_RUN) && (cnt_q >= per_q - WIDTH'(1));
      // Settings may change whenever the current period is not being continued.
      apply = (state_q == ST_IDLE) || !ENABLE[i] || wrap || sync_s;

      sh_per_d = LOAD[i] ? per_in : sh_per_q;
      sh_hi_d  = LOAD[i] ? hi_in  : sh_hi_q;
      per_d    = apply ? per_new : per_q;
      hi_d     = apply ? hi_new  : hi_q;
      pend_d   = apply ? 1'b0 : (pend_q | LOAD[i]);

      state_d = (ENABLE[i] && (per_d >= MIN_PERIOD)) ? ST_RUN : ST_IDLE;

      cnt_d = '0;
      if ((state_d == ST_RUN) && (state_q == ST_RUN) && !wrap && !sync_s) begin
        cnt_d = cnt_q + WIDTH'(1);
      end

      clk_d  = (state_d == ST_RUN) && (cnt_d < hi_d);
      tick_d = (state_d == ST_RUN) && (cnt_d == '0);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        per_q    <= '0;
        hi_q     <= '0;
        sh_per_q <= '0;
        sh_hi_q  <= '0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        per_q    <= per_d;
        hi_q     <= hi_d;
        sh_per_q <= sh_per_d;
        sh_hi_q  <= sh_hi_d;
        pend_q   <= pend_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    assign CLK_OUT[i] = clk_q;
    assign TICK[i]    = tick_q;
    assign PENDING[i] = pend_q;
  end

endmodule

// File: tb/tb_multi_channel_clock_generator.sv
// Randomised and directed bench for multi_channel_clock_generator against a per-period behavioural model.
module tb_multi_channel_clock_generator;
  localparam int N_CH  = 4;
  localparam int WIDTH = 32;

  logic                  CLOCK = 1'b0;
  logic                  RESET_N;
  logic [N_CH-1:0]       ENABLE, LOAD;
  logic [N_CH*WIDTH-1:0] PERIOD, HIGH_TIME;
  logic                  SYNC;
  logic [N_CH-1:0]       CLK_OUT, TICK, PENDING;

  int n_cmp = 0;
  int n_err = 0;

  // Model: each channel is either running at some phase within its period, or stopped.
  longint m_p[N_CH], m_h[N_CH], m_sp[N_CH], m_sh[N_CH], m_ph[N_CH];
  bit     m_run[N_CH], m_pend[N_CH];

  multi_channel_clock_generator #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .ENABLE    (ENABLE),
    .LOAD      (LOAD),
    .PERIOD    (PERIOD),
    .HIGH_TIME (HIGH_TIME),
`ifdef CLKGEN_SYNC_START_EN
    .SYNC      (SYNC),
`endif
    .CLK_OUT   (CLK_OUT),
    .TICK      (TICK),
    .PENDING   (PENDING)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_p[c] = 0; m_h[c] = 0; m_sp[c] = 0; m_sh[c] = 0; m_ph[c] = 0;
      m_run[c] = 0; m_pend[c] = 0;
    end
  endfunction

  // A running period continues unless it ends, is disabled or is re-aligned; otherwise the
  // newest setting takes effect and the channel (re)starts at phase 0 if it can run.
  function automatic void model_step();
    for (int c = 0; c < N_CH; c++) begin
      longint pin, hin, np, nh;
      bit     cont;
      pin  = longint'({32'h0, PERIOD[c*WIDTH +: WIDTH]});
      hin  = longint'({32'h0, HIGH_TIME[c*WIDTH +: WIDTH]});
      cont = m_run[c] && ENABLE[c] && !SYNC && (m_ph[c] != m_p[c] - 1);
      np   = LOAD[c] ? pin : (m_pend[c] ? m_sp[c] : m_p[c]);
      nh   = LOAD[c] ? hin : (m_pend[c] ? m_sh[c] : m_h[c]);
      if (LOAD[c]) begin
        m_sp[c] = pin;
        m_sh[c] = hin;
      end
      if (cont) begin
        m_ph[c] = m_ph[c] + 1;
        if (LOAD[c]) m_pend[c] = 1;
      end else begin
        m_p[c]    = np;
        m_h[c]    = nh;
        m_pend[c] = 0;
        m_run[c]  = ENABLE[c] && (np >= 2);
        m_ph[c]   = 0;
      end
    end
  endfunction

  function automatic logic [3*N_CH-1:0] model_outs();
    logic [N_CH-1:0] c_o, t_o, p_o;
    for (int c = 0; c < N_CH; c++) begin
      c_o[c] = m_run[c] && (m_ph[c] < m_h[c]);
      t_o[c] = m_run[c] && (m_ph[c] == 0);
      p_o[c] = m_pend[c];
    end
    return {c_o, t_o, p_o};
  endfunction

  task automatic cyc();
    @(posedge CLOCK);
    if (!RESET_N) model_reset();
    else model_step();
    #1;
  endtask

  task automatic set_ch(input int c, input longint p, input longint h);
    PERIOD[c*WIDTH +: WIDTH]    = WIDTH'(p);
    HIGH_TIME[c*WIDTH +: WIDTH] = WIDTH'(h);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; ENABLE = '0; LOAD = '0; PERIOD = '0; HIGH_TIME = '0; SYNC = 1'b0;
    model_reset();
    cyc(); cyc();
    n_cmp++;
    if ({CLK_OUT, TICK, PENDING} !== '0) begin
      n_err++; $display("FAIL reset_hold act=%b exp=0", {CLK_OUT, TICK, PENDING});
    end
    RESET_N = 1'b1;
    set_ch(0, 4, 2); LOAD[0] = 1'b1;
    cyc();
    LOAD = '0; ENABLE[0] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cyc();
      n_cmp++;
      if ({CLK_OUT, TICK, PENDING} !== model_outs()) begin
        n_err++; $display("FAIL reset_prerun j=%0d act=%b exp=%b", j, {CLK_OUT, TICK, PENDING}, model_outs());
      end
    end
    #2 RESET_N = 1'b0;
    #1;
    n_cmp++;
    if ({CLK_OUT, TICK, PENDING} !== '0) begin
      n_err++; $display("FAIL reset_async act=%b exp=0", {CLK_OUT, TICK, PENDING});
    end
    model_reset();
    cyc();
    RESET_N = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cyc();
      n_cmp++;
      if ({CLK_OUT[0], TICK[0]} !== 2'b00 || {CLK_OUT, TICK, PENDING} !== model_outs()) begin
        n_err++; $display("FAIL reset_release_idle j=%0d act=%b exp=%b", j, {CLK_OUT, TICK, PENDING}, model_outs());
      end
    end
    ENABLE = '0;
    cyc();
  endtask

  task automatic test_basic_divide();
    set_ch(0, 10, 5); LOAD[0] = 1'b1;
    cyc();
    LOAD = '0; ENABLE[0] = 1'b1;
    for (int j = 0; j < 30; j++) begin
      cyc();
      n_cmp++;
      if (CLK_OUT[0] !== ((j % 10) < 5) || TICK[0] !== ((j % 10) == 0)) begin
        n_err++; $display("FAIL basic_wave j=%0d act=%b%b exp=%b%b", j, CLK_OUT[0], TICK[0], (j % 10) < 5, (j % 10) == 0);
      end
      n_cmp++;
      if ({CLK_OUT, TICK, PENDING} !== model_outs()) begin
        n_err++; $display("FAIL basic_model j=%0d act=%b exp=%b", j, {CLK_OUT, TICK, PENDING}, model_outs());
      end
    end
    ENABLE = '0;
    cyc();
  endtask

  task automatic test_reload();
    bit ep, ec, et;
    set_ch(1, 8, 2); LOAD[1] = 1'b1;
    cyc();
    LOAD = '0; ENABLE[1] = 1'b1;
    for (int j = 0; j < 24; j++) begin
      cyc();
      ep = (j >= 4) && (j < 8);
      ec = (j < 8) ? ((j % 8) < 2) : (((j - 8) % 4) < 3);
      et = (j < 8) ? (j == 0) : (((j - 8) % 4) == 0);
      n_cmp++;
      if ({PENDING[1], CLK_OUT[1], TICK[1]} !== {ep, ec, et}) begin
        n_err++; $display("FAIL reload j=%0d act=%b%b%b exp=%b%b%b", j, PENDING[1], CLK_OUT[1], TICK[1], ep, ec, et);
      end
      n_cmp++;
      if ({CLK_OUT, TICK, PENDING} !== model_outs()) begin
        n_err++; $display("FAIL reload_model j=%0d act=%b exp=%b", j, {CLK_OUT, TICK, PENDING}, model_outs());
      end
      if (j == 3) begin set_ch(1, 4, 3); LOAD[1] = 1'b1; end
      if (j == 4) LOAD = '0;
    end
    ENABLE = '0;
    cyc();
  endtask

  task automatic test_boundaries();
    set_ch(2, 7, 0); set_ch(3, 12, 12); set_ch(0, 1, 1);
    LOAD = 4'b1101;
    cyc();
    LOAD = '0; ENABLE = 4'b1101;
    for (int j = 0; j < 26; j++) begin
      cyc();
      n_cmp++;
      if ({CLK_OUT[2], TICK[2]} !== {1'b0, (j % 7) == 0}) begin
        n_err++; $display("FAIL bound_h0 j=%0d act=%b%b", j, CLK_OUT[2], TICK[2]);
      end
      n_cmp++;
      if ({CLK_OUT[3], TICK[3]} !== {1'b1, (j % 12) == 0}) begin
        n_err++; $display("FAIL bound_hp j=%0d act=%b%b", j, CLK_OUT[3], TICK[3]);
      end
      n_cmp++;
      if ({CLK_OUT[0], TICK[0]} !== 2'b00) begin
        n_err++; $display("FAIL bound_p1 j=%0d act=%b%b exp=00", j, CLK_OUT[0], TICK[0]);
      end
      n_cmp++;
      if ({CLK_OUT, TICK, PENDING} !== model_outs()) begin
        n_err++; $display("FAIL bound_model j=%0d act=%b exp=%b", j, {CLK_OUT, TICK, PENDING}, model_outs());
      end
    end
    ENABLE = '0;
    cyc();
  endtask

  task automatic test_simultaneous();
    bit ec, et;
    set_ch(0, 5, 2); LOAD[0] = 1'b1;
    cyc();
    LOAD = '0; ENABLE[0] = 1'b1;
    for (int j = 0; j < 13; j++) begin
      cyc();
      ec = (j < 5) ? (j < 2) : (((j - 5) % 3) < 1);
      et = (j < 5) ? (j == 0) : (((j - 5) % 3) == 0);
      n_cmp++;
      if ({PENDING[0], CLK_OUT[0], TICK[0]} !== {1'b0, ec, et}) begin
        n_err++; $display("FAIL wrap_bypass j=%0d act=%b%b%b exp=0%b%b", j, PENDING[0], CLK_OUT[0], TICK[0], ec, et);
      end
      if (j == 4) begin set_ch(0, 3, 1); LOAD[0] = 1'b1; end
      if (j == 5) LOAD = '0;
    end
    set_ch(0, 6, 4); LOAD[0] = 1'b1;
    cyc();
    n_cmp++;
    if (PENDING[0] !== 1'b1) begin
      n_err++; $display("FAIL pend_set act=%b exp=1", PENDING[0]);
    end
    LOAD = '0; ENABLE[0] = 1'b0;
    cyc();
    n_cmp++;
    if ({PENDING[0], CLK_OUT[0], TICK[0]} !== 3'b000 || {CLK_OUT, TICK, PENDING} !== model_outs()) begin
      n_err++; $display("FAIL disable_pend act=%b%b%b exp=000", PENDING[0], CLK_OUT[0], TICK[0]);
    end
    ENABLE[0] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      cyc();
      n_cmp++;
      if ({CLK_OUT[0], TICK[0]} !== {(k % 6) < 4, (k % 6) == 0}) begin
        n_err++; $display("FAIL disable_applied k=%0d act=%b%b exp=%b%b", k, CLK_OUT[0], TICK[0], (k % 6) < 4, (k % 6) == 0);
      end
    end
    ENABLE = '0;
    cyc();
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(29, 0) == 0) ENABLE[c] = ~ENABLE[c];
        LOAD[c] = ($urandom_range(7, 0) == 0);
        if ($urandom_range(49, 0) == 0) set_ch(c, 64'hFFFF_FFFF, $urandom_range(14, 0));
        else set_ch(c, $urandom_range(12, 0), $urandom_range(14, 0));
      end
`ifdef CLKGEN_SYNC_START_EN
      SYNC = ($urandom_range(39, 0) == 0);
`endif
      cyc();
      n_cmp++;
      if ({CLK_OUT, TICK, PENDING} !== model_outs()) begin
        n_err++; $display("FAIL random n=%0d act=%b exp=%b", n, {CLK_OUT, TICK, PENDING}, model_outs());
      end
    end
    ENABLE = '0; LOAD = '0; SYNC = 1'b0;
    cyc();
  endtask

`ifdef CLKGEN_SYNC_START_EN
  task automatic test_sync();
    set_ch(0, 6, 3); set_ch(1, 9, 4); LOAD = 4'b0011;
    cyc();
    LOAD = '0; ENABLE[0] = 1'b1;
    cyc(); cyc();
    ENABLE[1] = 1'b1;
    repeat ($urandom_range(5, 1)) cyc();
    SYNC = 1'b1;
    cyc();
    SYNC = 1'b0;
    n_cmp++;
    if (TICK[1:0] !== 2'b11) begin
      n_err++; $display("FAIL sync_align act=%b exp=11", TICK[1:0]);
    end
    for (int k = 1; k <= 18; k++) begin
      cyc();
      n_cmp++;
      if ((TICK[0] && TICK[1]) !== (k == 18) || TICK[0] !== ((k % 6) == 0)) begin
        n_err++; $display("FAIL sync_coincide k=%0d act=%b exp_both=%b", k, TICK[1:0], k == 18);
      end
    end
    ENABLE = '0;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_divide();
    test_reload();
    test_boundaries();
    test_simultaneous();
    test_random();
`ifdef CLKGEN_SYNC_START_EN
    test_sync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
